pacman_move_ctrl: RTL and testbench
===================================

// Module: pacman_move_ctrl
// PURPOSE
//  Upstream sequencer for the pac-man sprite drawer. Each move period it erases the sprite
//  at its current position, steps the position per joystick direction and redraws the sprite.
//  Drives the drawer's writeEn/startx/starty, consumes its done_print, and gates VGA plotting.
// PARAMETERS
//  START_X     8'd76   x position after reset
//  START_Y     7'd56   y position after reset
//  X_MIN       8'd0    lowest legal sprite origin x
//  X_MAX       8'd154  highest legal sprite origin x (160 - sprite width)
//  Y_MIN       7'd0    lowest legal sprite origin y
//  Y_MAX       7'd114  highest legal sprite origin y (120 - sprite height)
//  STEP        3'd1    pixels moved per move period
//  FRAMES      4'd4    frame_tick pulses per move period (1..15)
//  DRAW_TMO    8'd64   max cycles in ERASE/DRAW waiting for draw_done
// PORTS
//  clock       in   1  system clock
//  reset       in   1  synchronous, active-low
//  frame_tick  in   1  one-cycle pulse per VGA frame
//  dir         in   2  0=left 1=right 2=up 3=down
//  move_en     in   1  1 = step on next move period; 0 = redraw in place
//  draw_done   in   1  done_print from sprite drawer
//  draw_en     out  1  writeEn to sprite drawer
//  pos_x       out  8  startx to sprite drawer
//  pos_y       out  7  starty to sprite drawer
//  erase       out  1  1 = force VGA colour to black (erase pass)
//  plot        out  1  VGA write enable
//  sprite_dir  out  2  direction of sprite image to draw (last applied dir)
//  busy        out  1  1 in ERASE/UPDATE/DRAW
//  tmo_err     out  1  sticky: drawer failed to finish within DRAW_TMO
// BEHAVIOUR
//  Reset (clock edge with reset=0): state=INIT, pos=START_X/START_Y, sprite_dir=0,
//   draw_en=erase=plot=busy=tmo_err=0, frame count=0, pending tick=0. Reset mid-draw aborts at once.
//  States: INIT -> DRAW (first paint, no erase) -> WAIT -> ERASE -> UPDATE -> DRAW -> WAIT.
//  WAIT: count frame_tick; on count reaching FRAMES, clear count, go ERASE next cycle.
//  ERASE: draw_en=1, erase=1, plot=1, pos unchanged. DRAW: draw_en=1, erase=0, plot=1.
//  Drawer holds done_print high until its next enabled cycle, so draw_done is ignored in the
//   first cycle of ERASE/DRAW; from the 2nd cycle, draw_done=1 ends the state (draw_en=0 next cycle).
//  UPDATE (1 cycle, draw_en=0): if move_en, sample dir, sprite_dir<=dir, pos += / -= STEP on
//   the selected axis; result computed at 9/8-bit width, saturated to [X_MIN,X_MAX]/[Y_MIN,Y_MAX].
//   If move_en=0, pos and sprite_dir unchanged (sprite redrawn in place).
//  frame_tick during ERASE/UPDATE/DRAW sets a 1-deep pending flag; it is counted on WAIT entry.
//   Further ticks while pending are dropped.
//  Timeout: ERASE/DRAW cycle counter; reaching DRAW_TMO without draw_done -> tmo_err<=1 (sticky
//   until reset), draw_en=0, go WAIT (skip remaining pass). Counter clears on each state entry.
//  pos_x/pos_y only change in UPDATE; stable throughout ERASE/DRAW.
//  busy is registered, high for exactly the ERASE/UPDATE/DRAW span.
// CONFIGURATION
//  PACMAN_WRAP_EN defined: horizontal tunnel - stepping left below X_MIN gives X_MAX, right above
//   X_MAX gives X_MIN; vertical still saturates.
//  PACMAN_WRAP_EN undefined: both axes saturate at bounds.
// TESTING
//  Reset, drawer model (done after 25 cycles) -> INIT paint at (76,56) with erase=0, then WAIT, busy=0.
//  FRAMES=4, dir=1, move_en=1, 4 ticks -> ERASE at (76,56), UPDATE, DRAW at (77,56), sprite_dir=1.
//  pos_x=0, dir=0 -> pos_x stays 0; with PACMAN_WRAP_EN -> pos_x becomes 154.
//  draw_done held high from previous pass at ERASE entry -> ERASE lasts >=2 cycles, not 1.
//  Drawer never completes -> tmo_err=1 after 64 cycles, state WAIT, draw_en=0.
//  frame_tick in DRAW, then 3 ticks in WAIT -> next ERASE after 3rd WAIT tick; reset mid-ERASE -> INIT.

Source files
------------

// File: rtl/pacman_move_ctrl.sv
// Erase / step / redraw sequencer for the pac-man sprite drawer, one pass per move period.
// Define PACMAN_WRAP_EN for a horizontal tunnel (x wraps); otherwise both axes saturate.
module pacman_move_ctrl #(
    parameter logic [7:0] START_X  = 8'd76,
    parameter logic [6:0] START_Y  = 7'd56,
    parameter logic [7:0] X_MIN    = 8'd0,
    parameter logic [7:0] X_MAX    = 8'd154,
    parameter logic [6:0] Y_MIN    = 7'd0,
    parameter logic [6:0] Y_MAX    = 7'd114,
    parameter logic [2:0] STEP     = 3'd1,
    parameter logic [3:0] FRAMES   = 4'd4,
    parameter logic [7:0] DRAW_TMO = 8'd64
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic [1:0] dir,
    input  logic       move_en,
    input  logic       draw_done,
    output logic       draw_en,
    output logic [7:0] pos_x,
    output logic [6:0] pos_y,
    output logic       erase,
    output logic       plot,
    output logic [1:0] sprite_dir,
    output logic       busy,
    output logic       tmo_err
);

`ifdef PACMAN_WRAP_EN
    localparam logic [7:0] X_UNDER = X_MAX;
    localparam logic [7:0] X_OVER  = X_MIN;
`else
    localparam logic [7:0] X_UNDER = X_MIN;
    localparam logic [7:0] X_OVER  = X_MAX;
`endif

    typedef enum logic [2:0] {S_INIT, S_DRAW, S_WAIT, S_ERASE, S_UPDATE} state_t;

    state_t     state_reg, state_next;
    logic [7:0] tmo_cnt_reg, tmo_cnt_next;
    logic [3:0] frame_cnt_reg, frame_cnt_next;
    logic       pend_reg, pend_next;
    logic [7:0] x_reg, x_next;
    logic [6:0] y_reg, y_next;
    logic [1:0] dir_reg, dir_next;
    logic       tmo_reg, tmo_next;
    logic       draw_en_reg, erase_reg, busy_reg;

    logic [4:0] frame_sum;
    logic [7:0] x_dec;
    logic [8:0] x_inc;
    logic [6:0] y_dec;
    logic [7:0] y_inc;
    logic       x_lo, x_hi, y_lo, y_hi;
    logic       in_pass;

    // Bounds are tested one bit wider than the position so the step cannot wrap silently.
    assign x_dec     = x_reg - {5'd0, STEP};
    assign x_inc     = {1'b0, x_reg} + {6'd0, STEP};
    assign x_lo      = ({1'b0, x_reg} < ({1'b0, X_MIN} + {6'd0, STEP}));
    assign x_hi      = (x_inc > {1'b0, X_MAX});
    assign y_dec     = y_reg - {4'd0, STEP};
    assign y_inc     = {1'b0, y_reg} + {5'd0, STEP};
    assign y_lo      = ({1'b0, y_reg} < ({1'b0, Y_MIN} + {5'd0, STEP}));
    assign y_hi      = (y_inc > {1'b0, Y_MAX});
    assign frame_sum = {1'b0, frame_cnt_reg} + {4'd0, frame_tick} + {4'd0, pend_reg};
    assign in_pass   = (state_reg == S_ERASE) || (state_reg == S_UPDATE) || (state_reg == S_DRAW);

    always_comb begin
        state_next     = state_reg;
        frame_cnt_next = frame_cnt_reg;
        pend_next      = pend_reg;
        x_next         = x_reg;
        y_next         = y_reg;
        dir_next       = dir_reg;
        tmo_next       = tmo_reg;
        tmo_cnt_next   = 8'd0;

        case (state_reg)
            S_INIT: state_next = S_DRAW;
            S_DRAW, S_ERASE: begin
                // A stale done from the previous pass is still high in the first cycle.
                if ((tmo_cnt_reg != 8'd0) && draw_done) begin
                    state_next = (state_reg == S_ERASE) ? S_UPDATE : S_WAIT;
                end else if (tmo_cnt_reg == DRAW_TMO - 8'd1) begin
                    state_next = S_WAIT;
                    tmo_next   = 1'b1;
                end
            end
            S_UPDATE: begin
                state_next = S_DRAW;
                if (move_en) begin
                    dir_next = dir;
                    case (dir)
                        2'd0:    x_next = x_lo ? X_UNDER : x_dec;
                        2'd1:    x_next = x_hi ? X_OVER  : x_inc[7:0];
                        2'd2:    y_next = y_lo ? Y_MIN   : y_dec;
                        default: y_next = y_hi ? Y_MAX   : y_inc[6:0];
                    endcase
                end
            end
            S_WAIT: begin
                pend_next = 1'b0;
                if (frame_sum >= {1'b0, FRAMES}) begin
                    frame_cnt_next = 4'd0;
                    state_next     = S_ERASE;
                end else begin
                    frame_cnt_next = frame_sum[3:0];
                end
            end
            default: state_next = S_INIT;
        endcase

        if (frame_tick && in_pass) begin
            pend_next = 1'b1;
        end
        if ((state_next == state_reg) && ((state_reg == S_DRAW) || (state_reg == S_ERASE))) begin
            tmo_cnt_next = tmo_cnt_reg + 8'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg     <= S_INIT;
            tmo_cnt_reg   <= 8'd0;
            frame_cnt_reg <= 4'd0;
            pend_reg      <= 1'b0;
            x_reg         <= START_X;
            y_reg         <= START_Y;
            dir_reg       <= 2'd0;
            tmo_reg       <= 1'b0;
            draw_en_reg   <= 1'b0;
            erase_reg     <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            tmo_cnt_reg   <= tmo_cnt_next;
            frame_cnt_reg <= frame_cnt_next;
            pend_reg      <= pend_next;
            x_reg         <= x_next;
            y_reg         <= y_next;
            dir_reg       <= dir_next;
            tmo_reg       <= tmo_next;
            // Decoded from the next state so the flags line up exactly with the state.
            draw_en_reg   <= (state_next == S_DRAW) || (state_next == S_ERASE);
            erase_reg     <= (state_next == S_ERASE);
            busy_reg      <= (state_next == S_DRAW) || (state_next == S_ERASE) ||
                             (state_next == S_UPDATE);
        end
    end

    assign draw_en    = draw_en_reg;
    assign plot       = draw_en_reg;
    assign erase      = erase_reg;
    assign busy       = busy_reg;
    assign pos_x      = x_reg;
    assign pos_y      = y_reg;
    assign sprite_dir = dir_reg;
    assign tmo_err    = tmo_reg;

endmodule

// File: tb/tb_pacman_move_ctrl.sv
// Randomised bench for pacman_move_ctrl: a sprite-drawer model plus a pass-level reference
// model of position, phase and timeout behaviour, checked every cycle.
module tb_pacman_move_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       frame_tick = 1'b0;
    logic [1:0] dir = 2'd0;
    logic       move_en = 1'b0;
    logic       draw_done = 1'b0;
    logic       draw_en, erase, plot, busy, tmo_err;
    logic [7:0] pos_x;
    logic [6:0] pos_y;
    logic [1:0] sprite_dir;

    pacman_move_ctrl dut (
        .clock(clock), .reset(reset), .frame_tick(frame_tick), .dir(dir),
        .move_en(move_en), .draw_done(draw_done), .draw_en(draw_en), .pos_x(pos_x),
        .pos_y(pos_y), .erase(erase), .plot(plot), .sprite_dir(sprite_dir),
        .busy(busy), .tmo_err(tmo_err)
    );

    always #5 clock = ~clock;

`ifdef PACMAN_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif
    localparam int P_INIT = 0, P_DRAW = 1, P_WAIT = 2, P_ERASE = 3, P_UPDATE = 4;
    localparam int XMAX = 154, YMAX = 114, FRAMES = 4, TMO = 64;

    int n_tests = 0, n_fail = 0, cyc = 0;
    // reference model
    int m_ph, m_t, m_frames, m_x, m_y, m_sd;
    bit m_pend, m_tmo, m_valid = 1'b0;
    // drawer model
    bit drv_done = 1'b0, drv_act = 1'b0;
    int drv_cnt = 0, drv_lat = 1;
    // stimulus knobs
    int p_tick = 30, p_me = 75, fix_dir = -1, lat_lo = 2, lat_hi = 30;
    bit stuck = 1'b0;
    // observation helpers
    int prev_x = 76, run = 0, max_run = 0;
    bit saw_wl = 1'b0, saw_wr = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_vec();
        bit de, bz;
        de = (m_ph == P_DRAW) || (m_ph == P_ERASE);
        bz = de || (m_ph == P_UPDATE);
        return {10'd0, de, m_ph == P_ERASE, de, bz, m_tmo, m_sd[1:0], m_x[7:0], m_y[6:0]};
    endfunction

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    task automatic model_step(input bit rst_n, input bit tk, input int d, input bit me, input bit dn);
        int np, tot;
        bit was_busy;
        if (!rst_n) begin
            m_ph = P_INIT; m_t = 0; m_frames = 0; m_pend = 0;
            m_x = 76; m_y = 56; m_sd = 0; m_tmo = 0;
            return;
        end
        np = m_ph;
        was_busy = (m_ph == P_DRAW) || (m_ph == P_ERASE) || (m_ph == P_UPDATE);
        case (m_ph)
            P_INIT: np = P_DRAW;
            P_DRAW, P_ERASE: begin
                if (m_t >= 1 && dn) np = (m_ph == P_ERASE) ? P_UPDATE : P_WAIT;
                else if (m_t + 1 >= TMO) begin np = P_WAIT; m_tmo = 1; end
            end
            P_UPDATE: begin
                np = P_DRAW;
                if (me) begin
                    m_sd = d;
                    if (d == 0)      m_x = (m_x - 1 < 0)    ? (WRAP ? XMAX : 0) : m_x - 1;
                    else if (d == 1) m_x = (m_x + 1 > XMAX) ? (WRAP ? 0 : XMAX) : m_x + 1;
                    else if (d == 2) m_y = clampi(m_y - 1, 0, YMAX);
                    else             m_y = clampi(m_y + 1, 0, YMAX);
                end
            end
            default: begin
                tot = m_frames + int'(tk) + int'(m_pend);
                m_pend = 0;
                if (tot >= FRAMES) begin m_frames = 0; np = P_ERASE; end
                else m_frames = tot;
            end
        endcase
        if (tk && was_busy) m_pend = 1;
        m_t = (np == m_ph) ? m_t + 1 : 0;
        m_ph = np;
    endtask

    task automatic cycle(input bit rst_n);
        @(negedge clock);
        cyc++;
        if (m_valid)
            chk($sformatf("out_c%0d", cyc),
                {10'd0, draw_en, erase, plot, busy, tmo_err, sprite_dir, pos_x, pos_y}, exp_vec());
        if (prev_x == 0 && pos_x == 8'd154) saw_wl = 1;
        if (prev_x == 154 && pos_x == 8'd0) saw_wr = 1;
        prev_x = int'(pos_x);
        if (draw_en) run++;
        else begin
            if (run > max_run) max_run = run;
            run = 0;
        end

        reset      = rst_n;
        frame_tick = ($urandom_range(99) < p_tick);
        dir        = (fix_dir < 0) ? 2'($urandom_range(3)) : 2'(fix_dir);
        move_en    = ($urandom_range(99) < p_me);
        draw_done  = drv_done;

        if (!rst_n) begin
            drv_done = 0; drv_act = 0;
        end else if (draw_en) begin
            if (!drv_act) begin
                drv_act = 1; drv_cnt = 0; drv_done = 0;
                drv_lat = stuck ? 100000 : $urandom_range(lat_hi, lat_lo);
            end
            drv_cnt++;
            if (drv_cnt >= drv_lat) begin drv_done = 1; drv_act = 0; end
        end else begin
            drv_act = 0;
        end

        model_step(rst_n, frame_tick, int'(dir), move_en, draw_done);
        m_valid = 1;
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1);
    endtask

    initial begin
        bit found;
        cycle(1'b0);
        cycle(1'b0);
        @(posedge clock); #1;
        chk("rst_pos_x", pos_x, 76);
        chk("rst_pos_y", pos_y, 56);
        chk("rst_flags", {draw_en, erase, plot, busy, tmo_err, sprite_dir}, 7'd0);

        run_cycles(1500);
        $display("[TB] random segment done, cycle %0d pos=(%0d,%0d)", cyc, pos_x, pos_y);

        p_tick = 80; p_me = 100; lat_lo = 1; lat_hi = 4;
        fix_dir = 0; run_cycles(2500);
`ifdef PACMAN_WRAP_EN
        chk("left_wrap", saw_wl, 1);
`else
        chk("left_sat", pos_x, 0);
`endif
        $display("[TB] left run done, pos_x=%0d", pos_x);
        fix_dir = 2; run_cycles(1500);
        chk("up_sat", pos_y, 0);
        $display("[TB] up run done, pos_y=%0d", pos_y);
        fix_dir = 1; run_cycles(3000);
`ifdef PACMAN_WRAP_EN
        chk("right_wrap", saw_wr, 1);
`else
        chk("right_sat", pos_x, 154);
`endif
        $display("[TB] right run done, pos_x=%0d", pos_x);
        fix_dir = 3; run_cycles(2000);
        chk("down_sat", pos_y, 114);
        $display("[TB] down run done, pos_y=%0d", pos_y);

        fix_dir = -1; p_me = 75;
        chk("tmo_clear", tmo_err, 0);
        stuck = 1; max_run = 0; run = 0;
        run_cycles(400);
        stuck = 0;
        chk("tmo_len", max_run, TMO);
        run_cycles(200);
        chk("tmo_sticky", tmo_err, 1);
        $display("[TB] timeout segment done, longest draw_en run=%0d", max_run);

        found = 0;
        for (int i = 0; i < 500 && !found; i++) begin
            cycle(1'b1);
            if (m_ph == P_ERASE && m_t == 1) found = 1;
        end
        chk("erase_seen", found, 1);
        cycle(1'b0);
        @(posedge clock); #1;
        chk("rstmid_pos", {pos_x, pos_y}, {8'd76, 7'd56});
        chk("rstmid_flags", {draw_en, erase, busy, tmo_err}, 4'd0);
        $display("[TB] mid-erase reset done, cycle %0d", cyc);

        p_tick = 30; lat_lo = 2; lat_hi = 30;
        run_cycles(800);
        $display("[TB] final random segment done, cycle %0d", cyc);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
